// File: rtl/fifo_arb_pkg.sv
// Shared types and default parameters for the FIFO push arbiter and its
// round-robin picker.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_BURST_LEN  = 4;

    // Wide enough to hold BURST_LEN itself, so the count never wraps.
    function automatic int beat_cnt_width(input int burst_len);
        return $clog2(burst_len + 1);
    endfunction

endpackage

// File: rtl/fifo_push_arbiter_if.sv
// Producer-side handshake and FIFO write-port bundle of the push arbiter.
// master = the arbiter, slave = the producers plus the FIFO.
interface fifo_push_arbiter_if #(
    parameter int NUM_REQ    = fifo_arb_pkg::DEF_NUM_REQ,
    parameter int DATA_WIDTH = fifo_arb_pkg::DEF_DATA_WIDTH
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]                 req_valid;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]                 req_ready;
    logic                               fifo_push;
    logic [DATA_WIDTH-1:0]              fifo_wr_data;
    logic                               fifo_full;
    logic [IDX_W-1:0]                   grant_id;
    logic                               busy;

    modport master (
        input  req_valid, req_data, fifo_full,
        output req_ready, fifo_push, fifo_wr_data, grant_id, busy
    );

    modport slave (
        output req_valid, req_data, fifo_full,
        input  req_ready, fifo_push, fifo_wr_data, grant_id, busy
    );

endinterface

// File: rtl/fifo_push_arbiter_rr_pick.sv
// Combinational round-robin picker: the first requester at or after
// last+1 (mod NUM_REQ) that has req set wins.
module rr_pick #(
    parameter int NUM_REQ = fifo_arb_pkg::DEF_NUM_REQ
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last,
    output logic                       any,
    output logic [$clog2(NUM_REQ)-1:0] winner
);
    localparam int IDX_W = $clog2(NUM_REQ);

    always_comb begin
        // NOTE: every output gets a default before the search so that no path
        // leaves it unassigned, which would infer a latch.
        any    = 1'b0;
        winner = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!any && req[(int'(last) + i) % NUM_REQ]) begin
                any    = 1'b1;
                winner = IDX_W'((int'(last) + i) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter granting one producer at a time a burst of up to
// BURST_LEN beats into the write port of a synchronous FIFO.
module fifo_push_arbiter #(
    parameter int NUM_REQ    = fifo_arb_pkg::DEF_NUM_REQ,
    parameter int DATA_WIDTH = fifo_arb_pkg::DEF_DATA_WIDTH,
    parameter int BURST_LEN  = fifo_arb_pkg::DEF_BURST_LEN
) (
    input  logic                clk,
    input  logic                reset_n,
    fifo_push_arbiter_if.master bus
);
    import fifo_arb_pkg::*;

    localparam int                IDX_W     = $clog2(NUM_REQ);
    localparam int                BEAT_W    = beat_cnt_width(BURST_LEN);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_REQ - 1);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic [IDX_W-1:0]  r_grant_idx;
    logic [IDX_W-1:0]  w_grant_idx_nxt;
    logic [IDX_W-1:0]  r_last_grant;
    logic [IDX_W-1:0]  w_last_grant_nxt;
    logic [BEAT_W-1:0] r_beat_cnt;
    logic [BEAT_W-1:0] w_beat_cnt_nxt;

    logic              w_any;
    logic [IDX_W-1:0]  w_winner;
    logic              w_in_burst;
    logic              w_own_valid;
    logic              w_xfer;
    logic [NUM_REQ-1:0] w_ready;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req    (bus.req_valid),
        .last   (r_last_grant),
        .any    (w_any),
        .winner (w_winner)
    );

    assign w_in_burst  = (r_state == BURST);
    assign w_own_valid = bus.req_valid[r_grant_idx];
    // A release wins over full: with valid low nothing moves regardless.
    assign w_xfer      = w_in_burst & w_own_valid & ~bus.fifo_full;

    // Last grant resets to the top index so requester 0 is searched first.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_grant_idx  <= '0;
            r_last_grant <= LAST_IDX;
            r_beat_cnt   <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values,
            // independent of statement order.
            r_state      <= w_state_nxt;
            r_grant_idx  <= w_grant_idx_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_beat_cnt   <= w_beat_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_grant_idx_nxt  = r_grant_idx;
        w_last_grant_nxt = r_last_grant;
        w_beat_cnt_nxt   = r_beat_cnt;
        case (r_state)
            IDLE: begin
                w_beat_cnt_nxt = '0;
                if (w_any) begin
                    w_state_nxt      = BURST;
                    w_grant_idx_nxt  = w_winner;
                    w_last_grant_nxt = w_winner;
                end
            end
            BURST: begin
                if (!w_own_valid) begin
                    w_state_nxt    = IDLE;
                    w_beat_cnt_nxt = '0;
                end else if (w_xfer) begin
                    w_beat_cnt_nxt = r_beat_cnt + 1'b1;
                    if (r_beat_cnt == LAST_BEAT) begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        w_ready = '0;
        if (w_in_burst) begin
            w_ready[r_grant_idx] = ~bus.fifo_full;
        end
    end

    assign bus.req_ready    = w_ready;
    assign bus.fifo_push    = w_xfer;
    assign bus.fifo_wr_data = w_xfer ? bus.req_data[r_grant_idx] : '0;
    assign bus.grant_id     = w_in_burst ? r_grant_idx : '0;
    assign bus.busy         = w_in_burst;

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Directed and randomized bench for fifo_push_arbiter, checked cycle by cycle
// against a transaction-level model of the grant/burst rules.
module tb_fifo_push_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int BL = 4;
    localparam int IW = $clog2(N);

    typedef struct {
        int            id;
        logic [DW-1:0] data;
        int            cyc;
    } push_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    fifo_push_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();
    fifo_push_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    fifo_push_arbiter_if #(.NUM_REQ(2), .DATA_WIDTH(8)) bus1 ();
    fifo_push_arbiter #(.NUM_REQ(2), .DATA_WIDTH(8), .BURST_LEN(1)) dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus1)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model: owner (-1 = idle), beats taken in the current grant, last winner.
    int            m_owner;
    int            m_beats;
    int            m_last;
    logic [N-1:0]  en;
    logic [N-1:0]  v;
    logic          full;
    logic [DW-1:0] base [N];
    int            sent [N];
    int            avail [N];
    push_t         log_q [$];
    int            cyc;

    logic          o_busy;
    logic          o_push;
    logic [IW-1:0] o_gid;
    logic [N-1:0]  o_ready;
    logic [DW-1:0] o_data;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_beats = 0;
        m_last  = N - 1;
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            v[i]             = en[i] && (sent[i] < avail[i]);
            bus.req_data[i]  = base[i] + DW'(sent[i]);
        end
        bus.req_valid = v;
        bus.fifo_full = full;
    endtask

    function automatic push_t get_log(input int k);
        push_t p;
        p.id   = -1;
        p.data = '0;
        p.cyc  = -1000;
        if (k < log_q.size()) p = log_q[k];
        return p;
    endfunction

    // One clock: drive at negedge, check 1 ns later, advance model, wait next negedge.
    task automatic step();
        logic          e_busy;
        logic          e_push;
        logic [IW-1:0] e_gid;
        logic [N-1:0]  e_ready;
        logic [DW-1:0] e_data;
        push_t         p;
        drive_inputs();
        #1;
        if (!reset_n) model_reset();
        e_busy  = (m_owner >= 0);
        e_gid   = e_busy ? IW'(m_owner) : '0;
        e_ready = '0;
        e_push  = 1'b0;
        e_data  = '0;
        if (e_busy) begin
            e_ready[m_owner] = ~full;
            e_push           = v[m_owner] & ~full;
            if (e_push) e_data = base[m_owner] + DW'(sent[m_owner]);
        end
        o_busy  = bus.busy;
        o_push  = bus.fifo_push;
        o_gid   = bus.grant_id;
        o_ready = bus.req_ready;
        o_data  = bus.fifo_wr_data;
        check("busy",     64'(o_busy),  64'(e_busy));
        check("grant_id", 64'(o_gid),   64'(e_gid));
        check("ready",    64'(o_ready), 64'(e_ready));
        check("push",     64'(o_push),  64'(e_push));
        check("wr_data",  64'(o_data),  64'(e_data));
        if (o_push) begin
            p.id   = int'(o_gid);
            p.data = o_data;
            p.cyc  = cyc;
            log_q.push_back(p);
        end
        if (!reset_n) begin
            model_reset();
        end else if (m_owner < 0) begin
            for (int k = 1; k <= N; k++) begin
                if (m_owner < 0 && v[(m_last + k) % N]) m_owner = (m_last + k) % N;
            end
            if (m_owner >= 0) begin
                m_last  = m_owner;
                m_beats = 0;
            end
        end else if (!v[m_owner]) begin
            m_owner = -1;
        end else if (!full) begin
            sent[m_owner]++;
            m_beats++;
            if (m_beats == BL) m_owner = -1;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_until(input int target, input int budget);
        int b;
        b = budget;
        while (log_q.size() < target && b > 0) begin
            step();
            b--;
        end
        check("push_timeout", 64'(log_q.size() >= target), 64'(1));
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        en      = '0;
        full    = 1'b0;
        for (int i = 0; i < N; i++) begin
            sent[i]  = 0;
            avail[i] = 0;
            base[i]  = '0;
        end
        step();
        step();
        log_q.delete();
        reset_n = 1'b1;
        cyc     = 0;
    endtask

    initial begin
        push_t p;
        push_t q;
        bus.req_valid     = '0;
        bus.req_data      = '0;
        bus.fifo_full     = 1'b0;
        bus1.req_valid    = '0;
        bus1.req_data     = '0;
        bus1.fifo_full    = 1'b0;
        en                = '0;
        v                 = '0;
        full              = 1'b0;
        cyc               = 0;
        for (int i = 0; i < N; i++) begin
            base[i]  = '0;
            sent[i]  = 0;
            avail[i] = 0;
        end
        model_reset();
        @(negedge clk);

        // Reset held with every producer valid: outputs stay quiet.
        reset_n = 1'b0;
        en      = '1;
        for (int i = 0; i < N; i++) begin
            avail[i] = 10;
            base[i]  = DW'(32'h10 * (i + 1));
        end
        step();
        check("rst_busy",  64'(o_busy),  64'(0));
        check("rst_ready", 64'(o_ready), 64'(0));
        step();
        reset_n = 1'b1;
        step();
        check("rel_idle", 64'(o_busy), 64'(0));
        step();
        check("rel_busy", 64'(o_busy), 64'(1));
        check("rel_gid",  64'(o_gid),  64'(0));

        // Full burst from requester 2, then a regrant for the tail.
        do_reset();
        en[2] = 1'b1; base[2] = 32'hA0; avail[2] = 6;
        for (int k = 0; k < 12; k++) step();
        check("burst_count", 64'(log_q.size()), 64'(6));
        for (int k = 0; k < 6; k++) begin
            p = get_log(k);
            check("burst_id",   64'(p.id),   64'(2));
            check("burst_data", 64'(p.data), 64'(32'hA0 + k));
        end
        p = get_log(3); q = get_log(4);
        check("burst_gap", 64'(q.cyc - p.cyc), 64'(2));

        // Rotation with all four producers continuously valid.
        do_reset();
        en = '1;
        for (int i = 0; i < N; i++) begin
            base[i]  = DW'(32'h100 * i);
            avail[i] = 8;
        end
        run_until(20, 200);
        for (int k = 0; k < 20; k++) begin
            p = get_log(k);
            check("rot_id",   64'(p.id),   64'((k / 4) % 4));
            check("rot_data", 64'(p.data), 64'(32'h100 * ((k / 4) % 4) + 4 * (k / 16) + k % 4));
        end
        for (int g = 1; g < 5; g++) begin
            p = get_log(4 * g - 1); q = get_log(4 * g);
            check("rot_gap", 64'(q.cyc - p.cyc), 64'(2));
        end

        // FIFO full for three cycles after the second beat of requester 1.
        do_reset();
        en[1] = 1'b1; base[1] = 32'hB0; avail[1] = 4;
        run_until(2, 20);
        full = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("stall_push",  64'(o_push),  64'(0));
            check("stall_ready", 64'(o_ready), 64'(0));
            check("stall_busy",  64'(o_busy),  64'(1));
        end
        full = 1'b0;
        run_until(4, 20);
        for (int k = 0; k < 4; k++) begin
            p = get_log(k);
            check("stall_data", 64'(p.data), 64'(32'hB0 + k));
        end
        p = get_log(1); q = get_log(2);
        check("stall_gap", 64'(q.cyc - p.cyc), 64'(4));

        // Requester 3 releases after two beats; rotation resumes at 0.
        do_reset();
        en[3] = 1'b1; base[3] = 32'hC0; avail[3] = 2;
        run_until(2, 20);
        en = '1;
        for (int i = 0; i < 3; i++) begin
            base[i]  = DW'(32'hD0 + 32'h100 * i);
            avail[i] = 8;
        end
        step();
        check("rls_busy", 64'(o_busy), 64'(1));
        check("rls_push", 64'(o_push), 64'(0));
        step();
        check("rls_idle", 64'(o_busy), 64'(0));
        step();
        check("rls_gid",  64'(o_gid),  64'(0));
        check("rls_next", 64'(o_busy), 64'(1));
        run_until(7, 30);
        for (int k = 2; k < 6; k++) begin
            p = get_log(k);
            check("rls_id",   64'(p.id),   64'(0));
            check("rls_data", 64'(p.data), 64'(32'hD0 + k - 2));
        end
        p = get_log(6);
        check("rls_after", 64'(p.id), 64'(1));

        // Reset pulse during beat 2 of requester 1.
        do_reset();
        en[1] = 1'b1; base[1] = 32'hE0; avail[1] = 8;
        run_until(1, 20);
        reset_n = 1'b0;
        en[0] = 1'b1; base[0] = 32'hF0; avail[0] = 8;
        step();
        check("mrst_busy",  64'(o_busy),  64'(0));
        check("mrst_push",  64'(o_push),  64'(0));
        check("mrst_ready", 64'(o_ready), 64'(0));
        step();
        reset_n = 1'b1;
        step();
        step();
        check("mrst_gid",  64'(o_gid),  64'(0));
        check("mrst_busy2", 64'(o_busy), 64'(1));

        // BURST_LEN = 1 instance: one beat per grant, alternating owners.
        do_reset();
        bus1.req_valid = 2'b11;
        bus1.req_data  = {8'h22, 8'h11};
        for (int c = 0; c < 8; c++) begin
            #1;
            check("bl1_busy", 64'(bus1.busy), 64'(c % 2));
            if (c % 2 == 1) begin
                check("bl1_gid",   64'(bus1.grant_id),     64'(((c - 1) / 2) % 2));
                check("bl1_push",  64'(bus1.fifo_push),    64'(1));
                check("bl1_data",  64'(bus1.fifo_wr_data), 64'((((c - 1) / 2) % 2 == 1) ? 8'h22 : 8'h11));
                check("bl1_ready", 64'(bus1.req_ready),    64'((((c - 1) / 2) % 2 == 1) ? 2'b10 : 2'b01));
            end else begin
                check("bl1_idle_push", 64'(bus1.fifo_push), 64'(0));
            end
            @(negedge clk);
        end
        bus1.req_valid = '0;

        // Randomized traffic: drops in valid, full pulses, rare resets.
        do_reset();
        for (int i = 0; i < N; i++) begin
            base[i]  = DW'($urandom);
            avail[i] = 1000000;
        end
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) en[i] = ($urandom_range(0, 7) != 0);
            full    = ($urandom_range(0, 3) == 0);
            reset_n = ($urandom_range(0, 199) != 0);
            step();
        end
        reset_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
